// File: rtl/nibble_add_seq_if.sv
// Request/result/slice bundle for nibble_add_seq. The op_sub_i signal exists only
// when NIBBLE_ADD_SUB_EN is defined.
interface nibble_add_seq_if #(
    parameter int WIDTH = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             cin_i;
`ifdef NIBBLE_ADD_SUB_EN
    logic             op_sub_i;
`endif
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] res_sum_o;
    logic             res_co_o;
    logic             busy_o;
    logic [3:0]       slice_a_o;
    logic [3:0]       slice_b_o;
    logic             slice_ci_o;
    logic [3:0]       slice_sum_i;
    logic             slice_co_i;

    // The sequencer is the slave of the request/result handshake and drives the slice.
    modport slave (
        input  req_valid_i, op_a_i, op_b_i, cin_i,
`ifdef NIBBLE_ADD_SUB_EN
        input  op_sub_i,
`endif
        input  res_ready_i, slice_sum_i, slice_co_i,
        output req_ready_o, res_valid_o, res_sum_o, res_co_o, busy_o,
        output slice_a_o, slice_b_o, slice_ci_o
    );

    modport master (
        output req_valid_i, op_a_i, op_b_i, cin_i,
`ifdef NIBBLE_ADD_SUB_EN
        output op_sub_i,
`endif
        output res_ready_i, slice_sum_i, slice_co_i,
        input  req_ready_o, res_valid_o, res_sum_o, res_co_o, busy_o,
        input  slice_a_o, slice_b_o, slice_ci_o
    );
endinterface

// File: rtl/nibble_add_seq.sv
// WIDTH-bit adder that reuses one external 4-bit slice, one nibble per clock, LSB first.
// Defining NIBBLE_ADD_SUB_EN adds op_sub_i for A-B (res_co_o=1 means no borrow).
module nibble_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    nibble_add_seq_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-5:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res_sum;
    logic               r_res_co;

    logic               w_req_ready;
    logic               w_res_valid;
    logic               w_busy;
    logic               w_run;
    logic               w_accept;
    logic               w_last;
    logic               w_sub_cur;
    logic               w_sub_req;
    logic               w_carry_init;
    logic [WIDTH-1:0]   w_sum_full;

`ifdef NIBBLE_ADD_SUB_EN
    logic r_sub;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= bus.op_sub_i;
        end
    end

    assign w_sub_cur = r_sub;
    assign w_sub_req = bus.op_sub_i;
`else
    assign w_sub_cur = 1'b0;
    assign w_sub_req = 1'b0;
`endif

    // Subtraction is A + ~B + 1, so the caller's carry-in is replaced by 1.
    assign w_carry_init = w_sub_req ? 1'b1 : bus.cin_i;
    assign w_last       = (r_cnt == CNT_W'(NIBBLES - 1));
    assign w_accept     = w_req_ready & bus.req_valid_i;
    // Only the upper WIDTH-4 bits of the sum shifter are stored; the newest nibble completes it.
    assign w_sum_full   = {bus.slice_sum_i, r_sum_sh};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = wb_rst_ni;
                if (bus.req_valid_i && wb_rst_ni) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_run  = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_res_valid = 1'b1;
                if (bus.res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: shift registers are reset too, so an aborted operation leaves no visible residue.
        if (!wb_rst_ni) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_res_sum <= '0;
            r_res_co  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= bus.op_a_i;
            r_b_sh  <= bus.op_b_i;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh   <= {4'h0, r_a_sh[WIDTH-1:4]};
            r_b_sh   <= {4'h0, r_b_sh[WIDTH-1:4]};
            r_sum_sh <= w_sum_full[WIDTH-1:4];
            r_carry  <= bus.slice_co_i;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_res_sum <= w_sum_full;
                r_res_co  <= bus.slice_co_i;
            end
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.res_valid_o = w_res_valid;
    assign bus.busy_o      = w_busy;
    assign bus.res_sum_o   = r_res_sum;
    assign bus.res_co_o    = r_res_co;
    assign bus.slice_a_o   = w_run ? r_a_sh[3:0] : 4'h0;
    assign bus.slice_b_o   = w_run ? (r_b_sh[3:0] ^ {4{w_sub_cur}}) : 4'h0;
    assign bus.slice_ci_o  = w_run & r_carry;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq at WIDTH=32 with a behavioural 4-bit slice.
module tb_nibble_add_seq;
    localparam int W = 32;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_sum;
    logic         last_co;
    int           waited;

    nibble_add_seq_if #(.WIDTH(W)) bus ();

    nibble_add_seq #(.WIDTH(W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    assign {bus.slice_co_i, bus.slice_sum_i} =
        5'(bus.slice_a_o) + 5'(bus.slice_b_o) + 5'(bus.slice_ci_o);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c0, input int k);
        logic [W:0]   s;
        logic [W-1:0] mask;
        mask = (k == 0) ? '0 : ({W{1'b1}} >> (W - 4 * k));
        s    = {1'b0, a & mask} + {1'b0, b & mask} + {{W{1'b0}}, c0};
        return s[4*k];
    endfunction

    // Results are compared on the falling edge before the consuming rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_sum", bus.res_sum_o, e.sum);
                check("res_co", bus.res_co_o, e.co);
            end
        end
    end

    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, output int n_wait);
        logic       acc;
        logic [W:0] full;
        exp_t       e;
        bus.op_a_i = a;
        bus.op_b_i = b;
        bus.cin_i  = cin;
`ifdef NIBBLE_ADD_SUB_EN
        bus.op_sub_i = sub;
`endif
        bus.req_valid_i = 1'b1;
        acc    = 1'b0;
        n_wait = 0;
        while (!acc && n_wait < 40) begin
            acc = bus.req_ready_o;
            @(posedge clk);
            #1;
            n_wait++;
        end
        check("accept", acc, 1);
        if (acc) begin
            if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            else     full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.sum = full[W-1:0];
            e.co  = full[W];
            sb.push_back(e);
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic run_nibbles(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic sub);
        logic [W-1:0] b_eff;
        logic         c0;
        b_eff = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
        for (int k = 0; k < N; k++) begin
            check($sformatf("slice_a[%0d]", k), bus.slice_a_o, (a >> (4 * k)) & 32'hF);
            check($sformatf("slice_b[%0d]", k), bus.slice_b_o, (b_eff >> (4 * k)) & 32'hF);
            check($sformatf("slice_ci[%0d]", k), bus.slice_ci_o, carry_into(a, b_eff, c0, k));
            check($sformatf("early_valid[%0d]", k), bus.res_valid_o, 0);
            check($sformatf("busy[%0d]", k), bus.busy_o, 1);
            check($sformatf("held_sum[%0d]", k), bus.res_sum_o, last_sum);
            @(posedge clk);
            #1;
        end
        check("latency_valid", bus.res_valid_o, 1);
        check("done_slice_zero", {bus.slice_a_o, bus.slice_b_o, bus.slice_ci_o}, 0);
    endtask

    task automatic consume();
        exp_t e;
        e = sb[0];
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready_i = 1'b0;
        check("valid_drop", bus.res_valid_o, 0);
        check("hold_sum", bus.res_sum_o, e.sum);
        check("hold_co", bus.res_co_o, e.co);
        last_sum = e.sum;
        last_co  = e.co;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
        int n;
        send_req(a, b, cin, sub, n);
        run_nibbles(a, b, cin, sub);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.cin_i       = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
        bus.op_sub_i    = 1'b0;
`endif
        bus.res_ready_i = 1'b0;
        last_sum        = '0;
        last_co         = 1'b0;

        #3;
        check("rst_req_ready", bus.req_ready_o, 0);
        check("rst_res_valid", bus.res_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_slice", {bus.slice_a_o, bus.slice_b_o, bus.slice_ci_o}, 0);
        check("rst_res", {bus.res_co_o, bus.res_sum_o}, 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.req_ready_o, 1);

        do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0);

        // Backpressure with a pending request, then simultaneous ready/valid in DONE.
        send_req(32'hA5A5_1234, 32'h5A5A_4321, 1'b0, 1'b0, waited);
        run_nibbles(32'hA5A5_1234, 32'h5A5A_4321, 1'b0, 1'b0);
        bus.op_a_i      = 32'h8000_0000;
        bus.op_b_i      = 32'h8000_0001;
        bus.cin_i       = 1'b1;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid[%0d]", i), bus.res_valid_o, 1);
            check($sformatf("bp_sum[%0d]", i), bus.res_sum_o, sb[0].sum);
            check($sformatf("bp_co[%0d]", i), bus.res_co_o, sb[0].co);
            check($sformatf("bp_ready[%0d]", i), bus.req_ready_o, 0);
            @(posedge clk);
            #1;
        end
        consume();
        check("bp_idle_ready", bus.req_ready_o, 1);
        check("bp_idle_busy", bus.busy_o, 0);
        send_req(32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0, waited);
        check("bp_accept_next_cycle", waited, 1);
        run_nibbles(32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0);
        consume();

        // Abort during nibble 3.
        send_req(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, waited);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        sb.delete(sb.size() - 1);
        last_sum = '0;
        last_co  = 1'b0;
        check("abort_res", {bus.res_co_o, bus.res_sum_o}, 0);
        check("abort_valid", bus.res_valid_o, 0);
        check("abort_busy", bus.busy_o, 0);
        check("abort_ready", bus.req_ready_o, 0);
        check("abort_slice", {bus.slice_a_o, bus.slice_b_o, bus.slice_ci_o}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_abort_valid[%0d]", i), bus.res_valid_o, 0);
        end
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef NIBBLE_ADD_SUB_EN
        do_op(32'd5, 32'd7, 1'b0, 1'b1);
        do_op(32'd7, 32'd5, 1'b1, 1'b1);
        do_op(32'd9, 32'd9, 1'b0, 1'b0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Sequencer that performs a WIDTH-bit addition by time-multiplexing one external 4-bit ripple adder slice, one nibble per clock, least-significant nibble first.
- Holds the inter-nibble carry in a register.
- Sits between user-project glue (wishbone/LA/IO capture logic) and the shared 4-bit adder slice.
- Exposes valid/ready request and result handshakes.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of 4 and >= 8. NIBBLES = WIDTH/4 is derived internally.

Ports:
- wb_clk_i  input  1  clock; all state updates on rising edge.
- wb_rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request operands valid.
- req_ready_o  output  1  block can accept a request.
- op_a_i  input  WIDTH  operand A.
- op_b_i  input  WIDTH  operand B.
- cin_i  input  1  carry-in to nibble 0.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  consumer accepts result.
- res_sum_o  output  WIDTH  sum.
- res_co_o  output  1  carry-out of the top nibble.
- busy_o  output  1  high in RUN or DONE.
- slice_a_o  output  4  A nibble to the adder slice.
- slice_b_o  output  4  B nibble to the adder slice.
- slice_ci_o  output  1  carry-in to the adder slice.
- slice_sum_i  input  4  slice sum. The slice is purely combinational, so this is valid in the same cycle.
- slice_co_i  input  1  slice carry-out.

Behaviour:
- Reset (wb_rst_ni=0, asynchronous):
  - State goes to IDLE.
  - Operand and sum shift registers, carry register, nibble counter, res_sum_o and res_co_o all clear to 0.
  - req_ready_o=1 only once reset is released; it is 0 while reset is asserted. res_valid_o=0, busy_o=0, slice_* outputs = 0.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: capture op_a_i/op_b_i into shift regs, carry <= cin_i, cnt <= 0, go to RUN.
- RUN:
  - req_ready_o=0.
  - slice_a_o = a_sh[3:0], slice_b_o = b_sh[3:0], slice_ci_o = carry.
  - Each edge: a_sh and b_sh shift right by 4; sum_sh shifts right by 4 with slice_sum_i entering at bits [WIDTH-1:WIDTH-4]; carry <= slice_co_i; cnt <= cnt+1.
  - On the edge where cnt==NIBBLES-1: load res_sum_o from the final sum_sh value (including this nibble) and res_co_o <= slice_co_i, then go to DONE.
- DONE:
  - res_valid_o=1. res_sum_o and res_co_o are stable.
  - On res_ready_i: go to IDLE.
  - res_ready_i is ignored in every other state.
- Latency: res_valid_o rises exactly NIBBLES edges after the accept edge (8 for WIDTH=32).
- Throughput: minimum NIBBLES+2 cycles per operation. No back-to-back accept while in DONE.
- slice_* outputs are 0 outside RUN.
- res_sum_o and res_co_o hold the last completed result until the next completion. They never show partial sums.
- req_valid_i during RUN or DONE is ignored. The requester holds its operands, and they are not sampled until IDLE.
- Wrap-around: the carry out of the top nibble goes only to res_co_o and never feeds back. The sum is modulo 2^WIDTH.
- Reset mid-operation aborts the operation. The partial result is discarded and res_valid_o never pulses for it.
- Simultaneous res_ready_i and req_valid_i while in DONE: only the result is consumed. The request is accepted in IDLE on the next cycle.

Optional Feature:
- Macro NIBBLE_ADD_SUB_EN.
- When defined: add input op_sub_i (1 bit), captured at accept.
  - If op_sub_i=1: slice_b_o = ~b_sh[3:0], initial carry = 1, and cin_i is ignored. The result is A-B modulo 2^WIDTH, with res_co_o=1 meaning no borrow.
  - If op_sub_i=0: behaviour is identical to addition.
- When undefined: port op_sub_i is absent; add only.

Test Plan (all at WIDTH=32):
- Basic add: A=0x00000001, B=0x00000001, cin=0 -> res_sum_o=0x00000002, res_co_o=0; res_valid_o rises exactly 8 edges after accept; slice_ci_o=0 on all nibbles.
- Full ripple: A=0xFFFFFFFF, B=0x00000001, cin=0 -> res_sum_o=0x00000000, res_co_o=1; slice_ci_o=1 for nibbles 1..7.
- Carry-in path: A=0x0F0F0F0F, B=0xF0F0F0F0, cin=1 -> res_sum_o=0x00000000, res_co_o=1.
- Backpressure: hold res_ready_i=0 for 5 cycles after valid while req_valid_i=1 with new operands -> res_valid_o and the result stay stable, req_ready_o=0, nothing accepted; after the result handshake, the new request is accepted the next cycle and computes correctly.
- Abort: assert wb_rst_ni=0 during nibble 3 -> all outputs 0 immediately, with no result pulse; after release, A=0x12345678, B=0x11111111 -> 0x23456789, co=0.
- With NIBBLE_ADD_SUB_EN: A=5, B=7, sub -> 0xFFFFFFFE, co=0. A=7, B=5, sub -> 0x00000002, co=1.
